// File: rtl/shift_register_univ.sv
// Universal WIDTH-bit register with parallel load, clear, shifts and rotates.
// Counts shifting operations and pulses word_done after every WIDTH of them.
module shift_register_univ #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             ser_in,
    output logic [WIDTH-1:0] q,
    output logic             ser_out_msb,
    output logic             ser_out_lsb,
    output logic             word_done
);

    localparam int               CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        M_HOLD = 3'b000,
        M_LOAD = 3'b001,
        M_SHL  = 3'b010,
        M_SHR  = 3'b011,
        M_ROL  = 3'b100,
        M_ROR  = 3'b101,
        M_ASR  = 3'b110,
        M_CLR  = 3'b111
    } mode_t;

    logic [WIDTH-1:0] r_q;
    logic [CNT_W-1:0] r_cnt;
    logic             r_word_done;

    mode_t            w_mode;
    logic [WIDTH-1:0] w_next_q;
    logic             w_counted;
    logic             w_clear_cnt;

    assign w_mode = mode_t'(mode);

    // Next register contents and counter classification for the selected mode
    always_comb begin
        w_next_q    = r_q;
        w_counted   = 1'b0;
        w_clear_cnt = 1'b0;
        case (w_mode)
            M_HOLD: begin
                w_next_q = r_q;
            end
            M_LOAD: begin
                w_next_q    = d;
                w_clear_cnt = 1'b1;
            end
            M_SHL: begin
                w_next_q  = {r_q[WIDTH-2:0], ser_in};
                w_counted = 1'b1;
            end
            M_SHR: begin
                w_next_q  = {ser_in, r_q[WIDTH-1:1]};
                w_counted = 1'b1;
            end
            M_ROL: begin
                w_next_q  = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
                w_counted = 1'b1;
            end
            M_ROR: begin
                w_next_q  = {r_q[0], r_q[WIDTH-1:1]};
                w_counted = 1'b1;
            end
            M_ASR: begin
                w_next_q  = {r_q[WIDTH-1], r_q[WIDTH-1:1]};
                w_counted = 1'b1;
            end
            M_CLR: begin
                // Clear goes to zero, deliberately not to RESET_VALUE
                w_next_q    = '0;
                w_clear_cnt = 1'b1;
            end
            default: begin
                w_next_q = r_q;
            end
        endcase
    end

    // Register update, word counter and one-cycle word_done pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q         <= RESET_VALUE;
            r_cnt       <= '0;
            r_word_done <= 1'b0;
        end else begin
            r_word_done <= 1'b0;
            if (en) begin
                r_q <= w_next_q;
                if (w_counted) begin
                    if (r_cnt == CNT_LAST) begin
                        r_cnt       <= '0;
                        r_word_done <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end else if (w_clear_cnt) begin
                    r_cnt <= '0;
                end
            end
        end
    end

    assign q           = r_q;
    assign word_done   = r_word_done;
    assign ser_out_msb = r_q[WIDTH-1];
    assign ser_out_lsb = r_q[0];

endmodule

// File: tb/tb_shift_register_univ.sv
// Scoreboard bench for shift_register_univ (WIDTH=8, RESET_VALUE=0).
module tb_shift_register_univ;

    localparam logic [2:0] HOLD = 3'b000, LOAD = 3'b001, SHL = 3'b010, SHR = 3'b011;
    localparam logic [2:0] ROL  = 3'b100, ROR  = 3'b101, ASR = 3'b110, CLR = 3'b111;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic [2:0] mode = HOLD;
    logic [7:0] d = 8'h00;
    logic       ser_in = 1'b0;
    logic [7:0] q;
    logic       ser_out_msb, ser_out_lsb, word_done;

    typedef struct {
        logic [7:0] q;
        logic       wd;
        int         id;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   step = 0;

    shift_register_univ #(.WIDTH(8), .RESET_VALUE(8'h00)) dut (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .d(d), .ser_in(ser_in),
        .q(q), .ser_out_msb(ser_out_msb), .ser_out_lsb(ser_out_lsb), .word_done(word_done)
    );

    always #5 clk = ~clk;

    // Monitor: every cycle after the edge, pop one expectation if one is pending
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            n_cmp++;
            if (q !== e.q || word_done !== e.wd || ser_out_msb !== e.q[7] || ser_out_lsb !== e.q[0]) begin
                n_fail++;
                $display("FAIL step%0d: got q=%h wd=%b msb=%b lsb=%b, want q=%h wd=%b msb=%b lsb=%b",
                         e.id, q, word_done, ser_out_msb, ser_out_lsb, e.q, e.wd, e.q[7], e.q[0]);
            end
        end
    end

    // Drive one operation on the falling edge and queue its expected result
    task automatic op(input logic e_i, input logic [2:0] m, input logic [7:0] dd,
                      input logic si, input logic [7:0] eq, input logic ewd);
        exp_t x;
        @(negedge clk);
        en = e_i; mode = m; d = dd; ser_in = si;
        step++;
        x.q = eq; x.wd = ewd; x.id = step;
        sb.push_back(x);
    endtask

    task automatic check_direct(input string name, input logic [7:0] eq, input logic ewd);
        n_cmp++;
        if (q !== eq || word_done !== ewd || ser_out_msb !== eq[7] || ser_out_lsb !== eq[0]) begin
            n_fail++;
            $display("FAIL %s: got q=%h wd=%b msb=%b lsb=%b, want q=%h wd=%b",
                     name, q, word_done, ser_out_msb, ser_out_lsb, eq, ewd);
        end
    endtask

    // Raise reset between edges, check immediately, hold two cycles, release on a falling edge
    task automatic async_reset(input string name);
        @(posedge clk);
        #3;
        en = 1'b0;
        reset = 1'b1;
        #1;
        check_direct({name, "_immediate"}, 8'h00, 1'b0);
        repeat (2) begin
            @(negedge clk);
            check_direct({name, "_held"}, 8'h00, 1'b0);
        end
        reset = 1'b0;
    endtask

    logic [7:0] desr_bits;
    logic [7:0] desr_q[8];
    logic [7:0] ror3c_q[8];
    logic [7:0] rol81_q[8];
    logic [7:0] gate_q[8];

    initial begin
        desr_bits = 8'b1011_0010;   // sent MSB first: 1,0,1,1,0,0,1,0
        desr_q  = '{8'h01, 8'h02, 8'h05, 8'h0B, 8'h16, 8'h2C, 8'h59, 8'hB2};
        ror3c_q = '{8'h1E, 8'h0F, 8'h87, 8'hC3, 8'hE1, 8'hF0, 8'h78, 8'h3C};
        rol81_q = '{8'h03, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h60, 8'hC0, 8'h81};
        gate_q  = '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF};

        // Reset state
        repeat (2) @(negedge clk);
        check_direct("reset_state", 8'h00, 1'b0);
        reset = 1'b0;

        // Asynchronous reset from a loaded 0xFF
        op(1, LOAD, 8'hFF, 0, 8'hFF, 0);
        async_reset("async_ff");

        // Single operations from 0xA5
        op(1, LOAD, 8'hA5, 0, 8'hA5, 0);  op(1, SHL, 8'h00, 1, 8'h4B, 0);
        op(1, LOAD, 8'hA5, 0, 8'hA5, 0);  op(1, SHR, 8'h00, 0, 8'h52, 0);
        op(1, LOAD, 8'hA5, 0, 8'hA5, 0);  op(1, ROL, 8'h00, 0, 8'h4B, 0);
        op(1, LOAD, 8'hA5, 0, 8'hA5, 0);  op(1, ROR, 8'h00, 1, 8'hD2, 0);
        op(1, LOAD, 8'hA5, 0, 8'hA5, 0);  op(1, ASR, 8'h00, 0, 8'hD2, 0);
        op(1, LOAD, 8'h25, 0, 8'h25, 0);  op(1, ASR, 8'h00, 1, 8'h12, 0);

        // Deserialise 0xB2 via SHL
        op(1, CLR, 8'hFF, 1, 8'h00, 0);
        for (int i = 0; i < 8; i++)
            op(1, SHL, 8'h00, desr_bits[7-i], desr_q[i], (i == 7));
        op(1, HOLD, 8'h00, 0, 8'hB2, 0);

        // Enable gating: 3 SHR, 5 idle cycles, 5 SHR
        op(1, CLR, 8'h00, 0, 8'h00, 0);
        for (int i = 0; i < 3; i++) op(1, SHR, 8'h00, 1, gate_q[i], 0);
        for (int i = 0; i < 5; i++) op(0, SHR, 8'h00, 1, 8'hE0, 0);
        for (int i = 3; i < 8; i++) op(1, SHR, 8'h00, 1, gate_q[i], (i == 7));
        op(1, HOLD, 8'h00, 0, 8'hFF, 0);

        // Counter restart by LOAD
        op(1, CLR, 8'h00, 0, 8'h00, 0);
        for (int i = 0; i < 5; i++) op(1, ROL, 8'h00, 0, 8'h00, 0);
        op(1, LOAD, 8'h3C, 0, 8'h3C, 0);
        for (int i = 0; i < 8; i++) op(1, ROR, 8'h00, 0, ror3c_q[i], (i == 7));
        op(1, HOLD, 8'h00, 0, 8'h3C, 0);

        // Counter restart by reset: after reset, 8 fresh counted ops from zero
        op(1, CLR, 8'h00, 0, 8'h00, 0);
        for (int i = 0; i < 5; i++) op(1, ROL, 8'h00, 0, 8'h00, 0);
        async_reset("reset_midword");
        for (int i = 0; i < 8; i++) op(1, ROR, 8'h00, 1, 8'h00, (i == 7));
        op(1, LOAD, 8'h3C, 0, 8'h3C, 0);
        for (int i = 0; i < 8; i++) op(1, ROR, 8'h00, 0, ror3c_q[i], (i == 7));

        // Continuous rotate: 24 ROL from 0x81, pulse every 8th
        op(1, LOAD, 8'h81, 0, 8'h81, 0);
        for (int i = 0; i < 24; i++) op(1, ROL, 8'h00, 0, rol81_q[i % 8], ((i % 8) == 7));

        // Reset while word_done is high clears it at once
        async_reset("reset_on_pulse");

        // All queued expectations must have been consumed
        @(posedge clk);
        #2;
        n_cmp++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: got %0d pending, want 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/shift_register_univ.md
# shift_register_univ

Parametrised universal register: a WIDTH-bit clocked storage element with enable, synchronous parallel load, synchronous clear, logical/arithmetic shifts and rotates in both directions, plus a serial-word counter that flags every completed WIDTH-bit serial transfer. It is the generalised successor of the single-bit reset-to-zero D flip-flop. It serves as the common data-holding, serialiser and deserialiser element for the flip-flop and register labs.

## Interface

Parameters:
- WIDTH, 8, register width in bits; legal range is WIDTH >= 2.
- RESET_VALUE, {WIDTH{1'b0}}, value loaded into q by reset.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  operation enable; when 0, q and cnt hold.
- mode  input  3  operation select (see Operation).
- d  input  WIDTH  parallel load data.
- ser_in  input  1  serial input bit for SHL and SHR.
- q  output  WIDTH  registered contents.
- ser_out_msb  output  1  combinational, equals q[WIDTH-1].
- ser_out_lsb  output  1  combinational, equals q[0].
- word_done  output  1  registered, one-cycle pulse after WIDTH counted shifts.

## Operation

- Reset (reset=1, asynchronous, no clock edge needed):
  - q = RESET_VALUE, internal cnt = 0, word_done = 0.
  - All three held for as long as reset is high.
- en=0 at a rising edge: q and cnt hold; word_done <= 0.
- en=1 at a rising edge, by mode:
  - 000 HOLD: q holds, cnt holds.
  - 001 LOAD: q <= d; cnt <= 0.
  - 010 SHL: q <= {q[WIDTH-2:0], ser_in}; counted.
  - 011 SHR: q <= {ser_in, q[WIDTH-1:1]}; counted.
  - 100 ROL: q <= {q[WIDTH-2:0], q[WIDTH-1]}; counted.
  - 101 ROR: q <= {q[0], q[WIDTH-1:1]}; counted.
  - 110 ASR: q <= {q[WIDTH-1], q[WIDTH-1:1]}; counted.
  - 111 CLR: q <= 0 (not RESET_VALUE); cnt <= 0.
- Counter:
  - cnt is clog2(WIDTH+1) bits wide.
  - On a counted operation with cnt == WIDTH-1: cnt <= 0 and word_done <= 1.
  - On any other counted operation: cnt <= cnt+1 and word_done <= 0.
  - On every non-counted operation (HOLD, LOAD, CLR, or en=0): word_done <= 0.
  - cnt never exceeds WIDTH-1.
  - Counted operations may be mixed freely in one word; every counted op advances cnt.
- Non-counted modes (HOLD, LOAD, CLR) never pulse word_done.

## Timing

- Operation latency: q reflects an operation one cycle after the edge on which en and mode are sampled.
- ser_out_msb and ser_out_lsb follow q with zero cycles of latency.
- word_done goes high in the cycle immediately after the edge that performs the WIDTH-th counted operation, and stays high for exactly one cycle unless the next operation also completes a word. Back-to-back pulses are impossible for WIDTH >= 2.
- Continuous counted operations produce one word_done pulse every WIDTH cycles.
- Reset asserted mid-word: cnt is discarded. After release, a full WIDTH counted ops are needed for the next pulse.
- Reset deassertion is synchronised outside this block. The first edge after release performs a normal operation.
- Inputs need only be stable around the rising edge; there is no handshake.

## Test plan

All scenarios use WIDTH=8, RESET_VALUE=0.

- Async reset: load 0xFF, then raise reset between clock edges -> q=0x00 and word_done=0 immediately, with no clock edge; q stays 0x00 while reset is held.
- Single ops from q=0xA5, en=1, one op each:
  - SHL with ser_in=1 -> 0x4B.
  - SHR with ser_in=0 -> 0x52.
  - ROL -> 0x4B.
  - ROR -> 0xD2.
  - ASR -> 0xD2.
  - ASR from 0x25 -> 0x12.
- Deserialise: CLR, then 8 SHL with ser_in = 1,0,1,1,0,0,1,0 -> q=0xB2 after the 8th edge; word_done=1 for exactly the following cycle, 0 otherwise.
- Enable gating: CLR, then 3 SHR, then en=0 for 5 cycles, then 5 more SHR -> no word_done while en=0; single pulse after the 8th counted shift; q unchanged during en=0.
- Counter restart:
  - CLR, 5 ROL, LOAD 0x3C, then 8 ROR -> word_done pulses only after the 8th ROR; q=0x3C at the end.
  - Same sequence with reset asserted after the 5 ROL, then released -> 8 fresh counted ops needed for the pulse.
- Continuous rotate: LOAD 0x81, then 24 consecutive ROL -> word_done pulses exactly 3 times, 8 cycles apart; q=0x81 at the end; ser_out_msb and ser_out_lsb track q[7] and q[0] every cycle.
